// File: rtl/fifo_ctrl.sv
// fifo_ctrl: control path of an 8-entry FIFO. It owns the handshake state machine,
// the head/tail pointers and the occupancy count. It drives the register-file write
// port and the downstream read-mux enable/select. It holds no data.
module fifo_ctrl #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic             we,
    output logic [PTR_W-1:0] wr_ptr,
    output logic             re,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] data_count,
    output logic             full,
    output logic             empty,
    output logic             wr_ack,
    output logic             wr_err,
    output logic             rd_ack,
    output logic             rd_err
);

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        NO_OP    = 3'd1,
        WRITE    = 3'd2,
        WR_ERROR = 3'd3,
        READ     = 3'd4,
        RD_ERROR = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;

    // Status flags come straight from the committed count, so they already
    // reflect a transfer during the cycle its ack is high.
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);

    // Next state, count and pointers; the decision is the same from every state.
    always_comb begin
        state_d = NO_OP;
        cnt_d   = cnt_q;
        head_d  = head_q;
        tail_d  = tail_q;

        if (wr_en && !rd_en) begin
            state_d = full ? WR_ERROR : WRITE;
        end else if (rd_en && !wr_en) begin
            state_d = empty ? RD_ERROR : READ;
        end

        // The count moves on the edge that enters a transfer state.
        if (state_d == WRITE) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (state_d == READ) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        // Pointers advance on the edge that ends a transfer cycle, so during the
        // transfer they still address the slot being accessed. Wrap is natural overflow.
        if (state_q == WRITE) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (state_q == READ) begin
            head_d = head_q + PTR_W'(1);
        end
    end

    // State, count and pointer registers with immediate asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        we     = (state_q == WRITE);
        wr_ack = (state_q == WRITE);
        re     = (state_q == READ);
        rd_ack = (state_q == READ);
        wr_err = (state_q == WR_ERROR);
        rd_err = (state_q == RD_ERROR);
    end

    assign wr_ptr     = tail_q;
    assign rd_ptr     = head_q;
    assign data_count = cnt_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Testbench for fifo_ctrl: directed request sequences with hand-computed expected
// outputs pushed into a scoreboard queue, popped and compared by a separate monitor.
module tb_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;
    localparam int CNT_W = 4;

    localparam int K_NOOP = 0;
    localparam int K_WR   = 1;
    localparam int K_WERR = 2;
    localparam int K_RD   = 3;
    localparam int K_RERR = 4;

    logic             clk;
    logic             reset_n;
    logic             wr_en;
    logic             rd_en;
    logic             we;
    logic [PTR_W-1:0] wr_ptr;
    logic             re;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] data_count;
    logic             full;
    logic             empty;
    logic             wr_ack;
    logic             wr_err;
    logic             rd_ack;
    logic             rd_err;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string       name;
        logic [17:0] vec;
    } exp_t;

    exp_t sb_q[$];

    fifo_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .we         (we),
        .wr_ptr     (wr_ptr),
        .re         (re),
        .rd_ptr     (rd_ptr),
        .data_count (data_count),
        .full       (full),
        .empty      (empty),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs the observable outputs: {we,re,wr_ack,wr_err,rd_ack,rd_err,full,empty,wr_ptr,rd_ptr,count}.
    function automatic logic [17:0] mk(int kind, int wp, int rp, int c);
        logic a_we, a_re, a_werr, a_rerr;
        a_we   = (kind == K_WR);
        a_re   = (kind == K_RD);
        a_werr = (kind == K_WERR);
        a_rerr = (kind == K_RERR);
        return {a_we, a_re, a_we, a_werr, a_re, a_rerr, (c == DEPTH), (c == 0),
                PTR_W'(wp), PTR_W'(rp), CNT_W'(c)};
    endfunction

    function automatic logic [17:0] dut_vec();
        return {we, re, wr_ack, wr_err, rd_ack, rd_err, full, empty, wr_ptr, rd_ptr, data_count};
    endfunction

    // Drive one request cycle and queue the outputs expected after the next rising edge.
    task automatic step(input string name, input logic w, input logic r,
                        input int kind, input int wp, input int rp, input int c);
        exp_t e;
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        e.name = name;
        e.vec  = mk(kind, wp, rp, c);
        sb_q.push_back(e);
    endtask

    // Monitor: after every rising edge, pop and compare; transfer/error flags with nothing queued are unexpected.
    initial begin
        exp_t e;
        logic [17:0] act;
        forever begin
            @(posedge clk);
            #1;
            act = dut_vec();
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                tests_run++;
                if (act !== e.vec) begin
                    tests_failed++;
                    $display("FAIL %s: got {we,re,wack,werr,rack,rerr,full,empty,wp,rp,cnt}=%b_%b_%b_%b_%b_%b_%b_%b_%0d_%0d_%0d expected %b_%b_%b_%b_%b_%b_%b_%b_%0d_%0d_%0d",
                             e.name, act[17], act[16], act[15], act[14], act[13], act[12], act[11], act[10],
                             act[9:7], act[6:4], act[3:0],
                             e.vec[17], e.vec[16], e.vec[15], e.vec[14], e.vec[13], e.vec[12], e.vec[11], e.vec[10],
                             e.vec[9:7], e.vec[6:4], e.vec[3:0]);
                end
            end else if (we || re || wr_err || rd_err || wr_ack || rd_ack) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_activity: got we=%b re=%b wr_err=%b rd_err=%b required all 0",
                         we, re, wr_err, rd_err);
            end
        end
    end

    // Check the asynchronous reset state directly, without any clock edge.
    task automatic check_reset(input string name);
        logic [17:0] act;
        act = dut_vec();
        tests_run++;
        if (act !== mk(K_NOOP, 0, 0, 0)) begin
            tests_failed++;
            $display("FAIL %s: got %b required %b", name, act, mk(K_NOOP, 0, 0, 0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        #2;
        check_reset("reset_initial");
        @(negedge clk);
        reset_n = 1'b1;

        step("idle_after_reset", 1'b0, 1'b0, K_NOOP, 0, 0, 0);

        // Reset pulse in the middle of a write burst.
        step("pre_wr0", 1'b1, 1'b0, K_WR, 0, 0, 1);
        step("pre_wr1", 1'b1, 1'b0, K_WR, 1, 0, 2);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset("reset_mid_burst");
        @(negedge clk);
        wr_en   = 1'b0;
        reset_n = 1'b1;

        // Fill: 8 writes, then one refused write.
        for (int i = 0; i < DEPTH; i++)
            step($sformatf("fill_wr%0d", i), 1'b1, 1'b0, K_WR, i, 0, i + 1);
        step("fill_wr_err", 1'b1, 1'b0, K_WERR, 0, 0, 8);

        // Drain: 8 reads, then one refused read.
        for (int i = 0; i < DEPTH; i++)
            step($sformatf("drain_rd%0d", i), 1'b0, 1'b1, K_RD, 0, i, 7 - i);
        step("drain_rd_err", 1'b0, 1'b1, K_RERR, 0, 0, 0);

        // Wrap: write 5, read 5, write 5.
        for (int i = 0; i < 5; i++)
            step($sformatf("wrap_wrA%0d", i), 1'b1, 1'b0, K_WR, i, 0, i + 1);
        for (int i = 0; i < 5; i++)
            step($sformatf("wrap_rd%0d", i), 1'b0, 1'b1, K_RD, 5, i, 4 - i);
        for (int i = 0; i < 5; i++)
            step($sformatf("wrap_wrB%0d", i), 1'b1, 1'b0, K_WR, (5 + i) % DEPTH, 5, i + 1);

        // Bring count to 3, then simultaneous and idle requests.
        step("to3_rd0", 1'b0, 1'b1, K_RD, 2, 5, 4);
        step("to3_rd1", 1'b0, 1'b1, K_RD, 2, 6, 3);
        step("both_req", 1'b1, 1'b1, K_NOOP, 2, 7, 3);
        step("both_req2", 1'b1, 1'b1, K_NOOP, 2, 7, 3);
        step("idle_req", 1'b0, 1'b0, K_NOOP, 2, 7, 3);

        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        for (int i = 0; i < 10 && sb_q.size() > 0; i++)
            @(negedge clk);
        if (sb_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
